// File: rtl/ntt_bfu_sequencer.sv
// ntt_bfu_sequencer
//   Drives the butterfly unit through every NTT/InvNTT layer of one polynomial
//   held in dual-port coefficient RAM. In each layer it issues one butterfly per
//   cycle: it reads the operand pair, forwards the read data and twiddle address
//   to the BFU on the following cycle, and writes each returning result pair back
//   to the addresses it was read from. A small in-flight FIFO pairs each result
//   with its addresses. Between layers the sequencer drains until every write of
//   the current layer has landed, because the next layer reads those words.
//
// Ports
//   clk_i, rstn_i                 clock, async active-low reset
//   start_i, abort_i              start (IDLE only) / cancel transform
//   selKD_i, selNTT_i             Kyber(1)/Dilithium(0), NTT(1)/InvNTT(0)
//   busy_o, done_o, error_o       status; error_o = result with empty FIFO
//   mem_re_o, mem_raddr{A,B}_o    RAM read, data returns next cycle
//   mem_rdata{A,B}_i              RAM read data
//   mem_we_o, mem_waddr{A,B}_o,
//   mem_wdata{A,B}_o              RAM write-back
//   bfu_valid_o, bfu_src{A,B}_o,
//   bfu_zeta_addr_o, bfu_sel*_o,
//   bfu_flush_o                   BFU request side
//   bfu_valid_i, bfu_result{A,B}_i BFU result side
module ntt_bfu_sequencer #(
   parameter int LOG_N   = 8,
   parameter int BFU_LAT = 5
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic             selKD_i,
   input  logic             selNTT_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             error_o,
   output logic             mem_re_o,
   output logic [LOG_N-1:0] mem_raddrA_o,
   output logic [LOG_N-1:0] mem_raddrB_o,
   input  logic [31:0]      mem_rdataA_i,
   input  logic [31:0]      mem_rdataB_i,
   output logic             mem_we_o,
   output logic [LOG_N-1:0] mem_waddrA_o,
   output logic [LOG_N-1:0] mem_waddrB_o,
   output logic [31:0]      mem_wdataA_o,
   output logic [31:0]      mem_wdataB_o,
   output logic             bfu_valid_o,
   output logic [31:0]      bfu_srcA_o,
   output logic [31:0]      bfu_srcB_o,
   output logic [15:0]      bfu_zeta_addr_o,
   output logic             bfu_selKD_o,
   output logic             bfu_selNTT_o,
   output logic             bfu_flush_o,
   input  logic             bfu_valid_i,
   input  logic [31:0]      bfu_resultA_i,
   input  logic [31:0]      bfu_resultB_i
);

   localparam int HALF  = (1 << LOG_N) / 2;
   localparam int BW    = LOG_N - 1;              // butterfly index width
   localparam int LGW   = $clog2(LOG_N);          // log2(len) width
   localparam int DEPTH = BFU_LAT + 2;
   localparam int PW    = $clog2(DEPTH);
   localparam int CW    = $clog2(DEPTH + 1);
   localparam int DW    = $clog2(BFU_LAT + 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

   state_t           r_state, w_state_nxt;
   logic [BW-1:0]    r_b;
   logic [LGW-1:0]   r_lglen;
   logic             r_selKD, r_selNTT;
   logic             r_vld;
   logic [LOG_N-1:0] r_k;
   logic             r_err;
   logic [DW-1:0]    r_drop;
   logic [PW-1:0]    r_wptr, r_rptr;
   logic [CW-1:0]    r_cnt;
   logic [2*LOG_N-1:0] r_fifo [DEPTH];

   logic             w_abort, w_start, w_push, w_accept, w_pop, w_err;
   logic             w_last_b, w_final, w_next_layer;
   logic [LGW-1:0]   w_lg_first, w_lg_min;
   logic [LOG_N-1:0] w_bx, w_len, w_g, w_j, w_raddrA, w_raddrB;
   logic [LOG_N-1:0] w_half_sh, w_k;
   logic [2*LOG_N-1:0] w_head;

   // Abort only means something once a transform is running.
   assign w_abort  = abort_i & (r_state != S_IDLE);
   assign w_start  = (r_state == S_IDLE) & start_i & ~abort_i;
   assign w_push   = (r_state == S_ISSUE) & ~w_abort;
   // Results landing inside the post-abort window belong to the cancelled run.
   assign w_accept = bfu_valid_i & ~w_abort & (r_drop == '0);
   assign w_pop    = w_accept & (r_cnt != '0);
   assign w_err    = w_accept & (r_cnt == '0);

   assign w_last_b = (r_b == BW'(HALF - 1));
   // Kyber stops one layer short: the len=1 layer is skipped.
   assign w_lg_min   = r_selKD ? LGW'(1) : '0;
   assign w_final    = r_selNTT ? (r_lglen == w_lg_min) : (r_lglen == LGW'(LOG_N - 1));
   assign w_lg_first = selNTT_i ? LGW'(LOG_N - 1) : (selKD_i ? LGW'(1) : '0);
   assign w_next_layer = (r_state == S_DRAIN) & (r_cnt == '0) & ~w_final & ~w_abort;

   // Butterfly b of a layer with len = 2**lglen:
   //   g = b >> lglen, j = b & (len-1), A = 2*len*g + j, B = A + len
   assign w_bx     = {1'b0, r_b};
   assign w_len    = LOG_N'(1) << r_lglen;
   assign w_g      = w_bx >> r_lglen;
   assign w_j      = w_bx & (w_len - LOG_N'(1));
   assign w_raddrA = ((w_g << 1) << r_lglen) | w_j;
   assign w_raddrB = w_raddrA + w_len;

   // NTT: k = N/(2len) + g. InvNTT: k = N/len - 1 - g, computed modulo 2**LOG_N
   // so the len=1 case (N - 1 - g) needs no extra bit.
   assign w_half_sh = LOG_N'(HALF) >> r_lglen;
   assign w_k       = r_selNTT ? (w_half_sh + w_g) : ((w_half_sh << 1) - LOG_N'(1) - w_g);

   assign w_head = r_fifo[r_rptr];

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start_i && !abort_i) w_state_nxt = S_ISSUE;
         S_ISSUE: if (w_last_b) w_state_nxt = S_DRAIN;
         S_DRAIN: if (r_cnt == '0) w_state_nxt = w_final ? S_DONE : S_ISSUE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      if (w_abort) w_state_nxt = S_IDLE;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state  <= S_IDLE;
         r_b      <= '0;
         r_lglen  <= '0;
         r_selKD  <= 1'b0;
         r_selNTT <= 1'b0;
         r_vld    <= 1'b0;
         r_k      <= '0;
         r_err    <= 1'b0;
         r_drop   <= '0;
      end else begin
         r_state <= w_state_nxt;
         // Read data arrives one cycle after the issue; k follows it.
         r_vld   <= w_push;
         r_k     <= w_k;
         if (w_start) begin
            r_selKD  <= selKD_i;
            r_selNTT <= selNTT_i;
            r_lglen  <= w_lg_first;
            r_b      <= '0;
            r_err    <= 1'b0;
         end else begin
            if (w_err) r_err <= 1'b1;
            // b wraps to 0 after the last butterfly, ready for the next layer.
            if (w_push) r_b <= r_b + BW'(1);
            if (w_next_layer)
               r_lglen <= r_selNTT ? (r_lglen - LGW'(1)) : (r_lglen + LGW'(1));
         end
         if (w_abort)
            r_drop <= DW'(BFU_LAT);
         else if (r_drop != '0)
            r_drop <= r_drop - DW'(1);
      end
   end

   // In-flight FIFO: occupancy is the number of butterflies awaiting write-back.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else if (w_abort) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_push) r_wptr <= (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + PW'(1);
         if (w_pop)  r_rptr <= (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + CW'(1);
            2'b01:   r_cnt <= r_cnt - CW'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int i = 0; i < DEPTH; i++) r_fifo[i] <= '0;
      end else if (w_push) begin
         r_fifo[r_wptr] <= {w_raddrA, w_raddrB};
      end
   end

   // Datapath outputs are gated to zero whenever their strobe is low.
   assign busy_o          = (r_state == S_ISSUE) | (r_state == S_DRAIN);
   assign done_o          = (r_state == S_DONE) & ~w_abort;
   assign error_o         = r_err;
   assign mem_re_o        = w_push;
   assign mem_raddrA_o    = w_push ? w_raddrA : '0;
   assign mem_raddrB_o    = w_push ? w_raddrB : '0;
   assign mem_we_o        = w_pop;
   assign mem_waddrA_o    = w_pop ? w_head[2*LOG_N-1:LOG_N] : '0;
   assign mem_waddrB_o    = w_pop ? w_head[LOG_N-1:0] : '0;
   assign mem_wdataA_o    = w_pop ? bfu_resultA_i : '0;
   assign mem_wdataB_o    = w_pop ? bfu_resultB_i : '0;
   assign bfu_valid_o     = r_vld;
   assign bfu_srcA_o      = r_vld ? mem_rdataA_i : '0;
   assign bfu_srcB_o      = r_vld ? mem_rdataB_i : '0;
   assign bfu_zeta_addr_o = r_vld ? 16'(r_k) : '0;
   assign bfu_selKD_o     = r_selKD;
   assign bfu_selNTT_o    = r_selNTT;
   assign bfu_flush_o     = w_abort;

endmodule

// File: tb/tb_ntt_bfu_sequencer.sv
// Bench for ntt_bfu_sequencer: RAM and BFU models, golden NTT/InvNTT written as
// the textbook nested loops, and per-scenario tasks with inline comparisons.
module tb_ntt_bfu_sequencer;
   localparam int LOG_N = 8;
   localparam int N     = 256;
   localparam int LAT   = 5;
   localparam int LCYC  = N / 2 + LAT + 2;
   localparam longint Q = 8380417;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   logic start = 0, abort = 0, selKD = 0, selNTT = 0;
   logic busy, done, err;
   logic mem_re, mem_we;
   logic [7:0] raddrA, raddrB, waddrA, waddrB;
   logic [31:0] rdA = 0, rdB = 0, wdA, wdB;
   logic bvalid_o, bselKD, bselNTT, bflush, bvalid_i;
   logic [31:0] srcA, srcB, resA, resB;
   logic [15:0] zaddr;

   ntt_bfu_sequencer #(.LOG_N(LOG_N), .BFU_LAT(LAT)) dut (
      .clk_i(clk), .rstn_i(rstn), .start_i(start), .abort_i(abort),
      .selKD_i(selKD), .selNTT_i(selNTT), .busy_o(busy), .done_o(done), .error_o(err),
      .mem_re_o(mem_re), .mem_raddrA_o(raddrA), .mem_raddrB_o(raddrB),
      .mem_rdataA_i(rdA), .mem_rdataB_i(rdB),
      .mem_we_o(mem_we), .mem_waddrA_o(waddrA), .mem_waddrB_o(waddrB),
      .mem_wdataA_o(wdA), .mem_wdataB_o(wdB),
      .bfu_valid_o(bvalid_o), .bfu_srcA_o(srcA), .bfu_srcB_o(srcB),
      .bfu_zeta_addr_o(zaddr), .bfu_selKD_o(bselKD), .bfu_selNTT_o(bselNTT),
      .bfu_flush_o(bflush), .bfu_valid_i(bvalid_i),
      .bfu_resultA_i(resA), .bfu_resultB_i(resB));

   logic [184:0] allout;
   assign allout = {busy, done, err, mem_re, raddrA, raddrB, mem_we, waddrA, waddrB, wdA, wdB,
                    bvalid_o, srcA, srcB, zaddr, bselKD, bselNTT, bflush};

   int checks = 0, errors = 0;

   function automatic longint zeta(input logic [7:0] k);
      return (longint'(k) * 7919 + 17) % Q;
   endfunction

   function automatic logic [63:0] bfly(input logic [31:0] a, input logic [31:0] b,
                                        input logic [7:0] k, input logic ntt);
      longint la, lb, z, t, x, y;
      la = longint'(a); lb = longint'(b); z = zeta(k);
      if (ntt) begin
         t = (z * lb) % Q; x = (la + t) % Q; y = (la - t + Q) % Q;
      end else begin
         x = (la + lb) % Q; y = (((la - lb + Q) % Q) * z) % Q;
      end
      return {x[31:0], y[31:0]};
   endfunction

   // RAM model: registered read, write at the edge.
   logic [31:0] mem [N];
   logic [31:0] gold [N];
   always @(posedge clk) begin
      if (mem_re) begin rdA <= mem[raddrA]; rdB <= mem[raddrB]; end
      if (mem_we) begin mem[waddrA] <= wdA; mem[waddrB] <= wdB; end
   end

   // BFU model: fixed latency, ignores flush so the DUT must drop late results.
   logic [LAT-1:0] pv;
   logic [31:0] pa [LAT];
   logic [31:0] pb [LAT];
   logic inj = 0;
   logic [63:0] bfu_r;
   assign bfu_r    = bfly(srcA, srcB, zaddr[7:0], bselNTT);
   assign bvalid_i = pv[LAT-1] | inj;
   assign resA     = pa[LAT-1];
   assign resB     = pb[LAT-1];
   always @(posedge clk or negedge rstn) begin
      if (!rstn) pv <= '0;
      else begin
         pv <= {pv[LAT-2:0], bvalid_o};
         pa[0] <= bfu_r[63:32];
         pb[0] <= bfu_r[31:0];
         for (int i = 1; i < LAT; i++) begin pa[i] <= pa[i-1]; pb[i] <= pb[i-1]; end
      end
   end

   // Issue/twiddle trace, sampled mid-cycle.
   logic [15:0] iss_q [$];
   logic [15:0] k_q [$];
   logic [31:0] exp_q [$];
   always @(negedge clk) begin
      if (mem_re) iss_q.push_back({raddrA, raddrB});
      if (bvalid_o) k_q.push_back(zaddr);
   end

   function automatic logic [31:0] trace_at(input int i);
      if (i < iss_q.size() && i < k_q.size()) return {iss_q[i], k_q[i]};
      return 32'hxxxx_xxxx;
   endfunction

   // Golden transform and expected issue order, from the reference loop nests.
   task automatic golden(input logic kd, input logic ntt);
      int len0, k;
      logic [63:0] r;
      len0 = kd ? 2 : 1;
      for (int i = 0; i < N; i++) gold[i] = mem[i];
      exp_q.delete();
      if (ntt) begin
         k = 0;
         for (int len = N / 2; len >= len0; len = len / 2)
            for (int st = 0; st < N; st = st + 2 * len) begin
               k++;
               for (int j = st; j < st + len; j++) begin
                  exp_q.push_back({8'(j), 8'(j + len), 16'(k)});
                  r = bfly(gold[j], gold[j + len], 8'(k), 1'b1);
                  gold[j] = r[63:32]; gold[j + len] = r[31:0];
               end
            end
      end else begin
         k = N / len0;
         for (int len = len0; len < N; len = len * 2)
            for (int st = 0; st < N; st = st + 2 * len) begin
               k--;
               for (int j = st; j < st + len; j++) begin
                  exp_q.push_back({8'(j), 8'(j + len), 16'(k)});
                  r = bfly(gold[j], gold[j + len], 8'(k), 1'b0);
                  gold[j] = r[63:32]; gold[j + len] = r[31:0];
               end
            end
      end
   endtask

   task automatic launch(input logic kd, input logic ntt);
      for (int i = 0; i < N; i++) mem[i] = $urandom_range(32'(Q - 1), 0);
      golden(kd, ntt);
      iss_q.delete(); k_q.delete();
      @(negedge clk); selKD = kd; selNTT = ntt; start = 1;
      @(negedge clk); start = 0;
   endtask

   // Full transform; spulse = cycle at which start_i is re-pulsed while busy.
   task automatic run_xform(input logic kd, input logic ntt, input int spulse, input string tag);
      int n, layers, bad;
      layers = kd ? LOG_N - 1 : LOG_N;
      launch(kd, ntt);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_rise got %b want 1", tag, busy); end
      n = 0;
      while (done !== 1'b1 && n < 4000) begin
         start = (n == spulse);
         @(negedge clk); n++;
      end
      start = 0;
      checks++;
      if (n !== layers * LCYC) begin
         errors++; $display("FAIL %s done_latency got %0d want %0d", tag, n, layers * LCYC);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL %s done_width got done=%b busy=%b want 0 0", tag, done, busy);
      end
      bad = 0;
      for (int i = 0; i < N; i++)
         if (mem[i] !== gold[i]) begin
            if (bad == 0) $display("FAIL %s mem[%0d] got %h want %h", tag, i, mem[i], gold[i]);
            bad++;
         end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL %s memory got %0d bad words want 0", tag, bad); end
      bad = 0;
      if (iss_q.size() != exp_q.size() || k_q.size() != exp_q.size()) bad = 1;
      else for (int i = 0; i < exp_q.size(); i++) if (trace_at(i) !== exp_q[i]) bad++;
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL %s issue_trace got %0d bad (len %0d) want 0 (len %0d)",
                            tag, bad, iss_q.size(), exp_q.size());
      end
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL %s error_o got %b want 0", tag, err); end
   endtask

   task automatic test_reset();
      rstn = 0;
      repeat (3) @(negedge clk);
      checks++;
      if (allout !== '0) begin errors++; $display("FAIL reset_outputs got %h want 0", allout); end
      rstn = 1;
      @(negedge clk);
      checks++;
      if (allout !== '0) begin errors++; $display("FAIL post_reset_idle got %h want 0", allout); end
   endtask

   task automatic test_ntt_dilithium();
      // start_i re-pulsed mid-run must not disturb timing or results
      run_xform(1'b0, 1'b1, 300, "dil_ntt");
      checks++;
      if (trace_at(5) !== 32'h0585_0001) begin
         errors++; $display("FAIL l0_b5 got %h want 05850001", trace_at(5));
      end
      checks++;
      if (trace_at(128 + 64) !== 32'h80C0_0003) begin
         errors++; $display("FAIL l1_b64 got %h want 80c00003", trace_at(192));
      end
   endtask

   task automatic test_intt_kyber();
      run_xform(1'b1, 1'b0, -1, "kyb_intt");
      checks++;
      if (trace_at(0) !== 32'h0002_007F) begin
         errors++; $display("FAIL kyb_first got %h want 0002007f", trace_at(0));
      end
      checks++;
      if (trace_at(6 * 128) !== 32'h0080_0001) begin
         errors++; $display("FAIL kyb_last_layer got %h want 00800001", trace_at(768));
      end
   endtask

   task automatic test_random_modes();
      for (int r = 0; r < 2; r++)
         run_xform(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                   int'($urandom_range(900, 10)), "rand_mode");
   endtask

   task automatic test_abort();
      int n, bad_we, bad_done, bad_err, bad_re;
      launch(1'b0, 1'b1);
      n = 0;
      while (n < 2 * LCYC + 40) begin @(negedge clk); n++; end
      abort = 1;
      #1;
      checks++;
      if (bflush !== 1'b1) begin errors++; $display("FAIL abort_flush got %b want 1", bflush); end
      @(negedge clk); abort = 0;
      checks++;
      if (bflush !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL abort_next got flush=%b busy=%b want 0 0", bflush, busy);
      end
      bad_we = 0; bad_done = 0; bad_err = 0; bad_re = 0;
      repeat (12) begin
         if (mem_we !== 1'b0) bad_we++;
         if (done !== 1'b0) bad_done++;
         if (err !== 1'b0) bad_err++;
         if (mem_re !== 1'b0) bad_re++;
         @(negedge clk);
      end
      checks++;
      if (bad_we != 0) begin errors++; $display("FAIL abort_writes got %0d want 0", bad_we); end
      checks++;
      if (bad_done != 0) begin errors++; $display("FAIL abort_done got %0d want 0", bad_done); end
      checks++;
      if (bad_err != 0) begin errors++; $display("FAIL abort_error got %0d want 0", bad_err); end
      checks++;
      if (bad_re != 0) begin errors++; $display("FAIL abort_reads got %0d want 0", bad_re); end
   endtask

   task automatic test_error_inject();
      int n;
      inj = 1;
      #1;
      checks++;
      if (mem_we !== 1'b0) begin errors++; $display("FAIL inject_we got %b want 0", mem_we); end
      @(negedge clk); inj = 0;
      checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL inject_error got %b want 1", err); end
      repeat (3) @(negedge clk);
      checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL error_sticky got %b want 1", err); end
      launch(1'b1, 1'b1);
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL error_clear got %b want 0", err); end
      n = 0;
      while (done !== 1'b1 && n < 4000) begin @(negedge clk); n++; end
      checks++;
      if (n !== (LOG_N - 1) * LCYC) begin
         errors++; $display("FAIL kyb_ntt_latency got %0d want %0d", n, (LOG_N - 1) * LCYC);
      end
   endtask

   task automatic test_reset_midlayer();
      int n, bad;
      launch(1'b1, 1'b1);
      n = 0;
      while (n < 200) begin
         start = (n == 50);
         @(negedge clk); n++;
      end
      start = 0;
      #2 rstn = 0;
      #1;
      checks++;
      if (allout !== '0) begin errors++; $display("FAIL midreset_outputs got %h want 0", allout); end
      bad = (iss_q.size() < 150) ? 1 : 0;
      for (int i = 0; i < iss_q.size() && i < exp_q.size(); i++)
         if (iss_q[i] !== exp_q[i][31:16]) bad++;
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL start_while_busy trace got %0d bad (len %0d) want 0", bad, iss_q.size());
      end
      @(negedge clk); rstn = 1;
      bad = 0;
      repeat (10) begin
         if (busy !== 1'b0 || done !== 1'b0 || mem_re !== 1'b0 || mem_we !== 1'b0 || err !== 1'b0) bad++;
         @(negedge clk);
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL post_midreset_idle got %0d busy cycles want 0", bad); end
   endtask

   initial begin
      test_reset();
      test_ntt_dilithium();
      test_intt_kyber();
      test_random_modes();
      test_abort();
      test_error_inject();
      test_reset_midlayer();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
